alu_op_sequencer: RTL and testbench

- Controller that shares one ALU datapath between two requesters over valid/ready handshakes.
- The ALU datapath covers add, subtract, signed multiply, shift and unsigned divide.
- Arbitration is round-robin. The block drives the ALU select and operand buses, holds them stable for a per-operation latency, captures and packs the result, and returns it with requester ID and status flags.
- Sits between bus-side requesters and the combinational ALU; mul/div are treated as multicycle paths.

---
 rtl/alu_ctrl_pkg.sv | 72 +++++++
 rtl/rr_arb2.sv | 33 +++
 rtl/alu_op_sequencer.sv | 157 +++++++++++++++
 tb/tb_alu_op_sequencer.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU operation sequencer: op codes, FSM state
// encoding, datapath widths, request payload and result packing helpers.
package alu_ctrl_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned RES_W  = 32;
    localparam int unsigned OP_W   = 3;

    localparam logic [OP_W-1:0] OP_ADD   = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB   = 3'b001;
    localparam logic [OP_W-1:0] OP_MUL   = 3'b010;
    localparam logic [OP_W-1:0] OP_SHIFT = 3'b011;
    localparam logic [OP_W-1:0] OP_DIV   = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // One requester's payload after the grant mux.
    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } alu_req_t;

    // Codes above DIV have no datapath behind them.
    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
        return op <= OP_DIV;
    endfunction

    // MUL and DIV are the multicycle paths through the ALU.
    function automatic logic op_is_slow(input logic [OP_W-1:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    // Build rsp_data from the ALU result buses for the given op.
    function automatic logic [RES_W-1:0] pack_result(
        input logic [OP_W-1:0]   op,
        input logic [DATA_W-1:0] y1,
        input logic [RES_W-1:0]  y2,
        input logic [DATA_W-1:0] y3
    );
        logic [RES_W-1:0] r;
        r = '0;
        case (op)
            OP_ADD, OP_SUB:   r = {{(RES_W-DATA_W){1'b0}}, y1};
            OP_MUL:           r = y2;
            OP_SHIFT, OP_DIV: r = {y3, y1};
            default:          r = '0;
        endcase
        return r;
    endfunction

    // Carry for ADD, overflow for SUB, nothing for the rest.
    function automatic logic pack_flag(
        input logic [OP_W-1:0] op,
        input logic            cout,
        input logic            m
    );
        logic f;
        f = 1'b0;
        case (op)
            OP_ADD:  f = cout;
            OP_SUB:  f = m;
            default: f = 1'b0;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant, purely combinational. The requester named by
// ptr wins when valid, otherwise the other one wins when valid.
// Ports:
//   req_valid  per-requester valid
//   ptr        current priority holder
//   gnt_valid  some requester is granted
//   gnt_id     index of the granted requester
//   gnt        one-hot grant (never both bits)
module rr_arb2 (
    input  logic [1:0] req_valid,
    input  logic       ptr,
    output logic       gnt_valid,
    output logic       gnt_id,
    output logic [1:0] gnt
);

    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = ptr;
        gnt       = 2'b00;
        if (req_valid[ptr]) begin
            gnt_valid = 1'b1;
            gnt_id    = ptr;
        end else if (req_valid[~ptr]) begin
            gnt_valid = 1'b1;
            gnt_id    = ~ptr;
        end
        if (gnt_valid) begin
            gnt[gnt_id] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Shares one combinational ALU between two valid/ready requesters. Grants
// round-robin, holds the ALU select/operands for the op's latency, captures
// and packs the result, then returns it with requester id and status flags.
// Ports:
//   clk, rst                       clock, async active-high reset
//   req_valid/req_ready            per-requester handshake (bit n = requester n)
//   req_op/req_a/req_b             {req1,req0} op code and operands
//   alu_sel/alu_opa/alu_opb        ALU select and operand buses
//   alu_cin/alu_sub                adder carry-in (0), subtract select
//   alu_y1/alu_y2/alu_y3           ALU result buses
//   alu_cout/alu_m                 adder carry-out, subtractor overflow
//   rsp_valid/rsp_ready            response handshake
//   rsp_id/rsp_data/rsp_flag/rsp_err  response payload
//   busy                           transaction in flight
module alu_op_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned LAT_FAST = 1,
    parameter int unsigned LAT_SLOW = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          req_valid,
    output logic [1:0]          req_ready,
    input  logic [2*OP_W-1:0]   req_op,
    input  logic [2*DATA_W-1:0] req_a,
    input  logic [2*DATA_W-1:0] req_b,
    output logic [OP_W-1:0]     alu_sel,
    output logic [DATA_W-1:0]   alu_opa,
    output logic [DATA_W-1:0]   alu_opb,
    output logic                alu_cin,
    output logic                alu_sub,
    input  logic [DATA_W-1:0]   alu_y1,
    input  logic [RES_W-1:0]    alu_y2,
    input  logic [DATA_W-1:0]   alu_y3,
    input  logic                alu_cout,
    input  logic                alu_m,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_id,
    output logic [RES_W-1:0]    rsp_data,
    output logic                rsp_flag,
    output logic                rsp_err,
    output logic                busy
);

    localparam int unsigned LAT_MAX = (LAT_FAST > LAT_SLOW) ? LAT_FAST : LAT_SLOW;
    localparam int unsigned CNT_W   = $clog2(LAT_MAX + 1);

    state_t           state;
    logic             ptr;
    logic [CNT_W-1:0] cnt;

    logic             gnt_valid;
    logic             gnt_id;
    logic [1:0]       gnt;
    alu_req_t         sel_req;
    logic             acc_err;

    rr_arb2 u_arb (
        .req_valid (req_valid),
        .ptr       (ptr),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id),
        .gnt       (gnt)
    );

    // Ready is only offered while idle, to the granted requester.
    assign req_ready = (state == ST_IDLE) ? gnt : 2'b00;
    assign alu_cin   = 1'b0;

    // Payload of the granted requester.
    always_comb begin
        sel_req.op = gnt_id ? req_op[2*OP_W-1:OP_W]     : req_op[OP_W-1:0];
        sel_req.a  = gnt_id ? req_a[2*DATA_W-1:DATA_W]  : req_a[DATA_W-1:0];
        sel_req.b  = gnt_id ? req_b[2*DATA_W-1:DATA_W]  : req_b[DATA_W-1:0];
    end

    // Requests answered with an error without touching the ALU.
    assign acc_err = !op_is_legal(sel_req.op) ||
                     ((sel_req.op == OP_DIV) && (sel_req.b == '0));

    // Sequencer FSM with all datapath and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            ptr       <= 1'b0;
            cnt       <= '0;
            alu_sel   <= '0;
            alu_opa   <= '0;
            alu_opb   <= '0;
            alu_sub   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            rsp_flag  <= 1'b0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gnt_valid) begin
                        busy   <= 1'b1;
                        rsp_id <= gnt_id;
                        if (acc_err) begin
                            state     <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_data  <= '0;
                            rsp_flag  <= 1'b0;
                        end else begin
                            state   <= ST_EXEC;
                            cnt     <= op_is_slow(sel_req.op) ? CNT_W'(LAT_SLOW)
                                                              : CNT_W'(LAT_FAST);
                            alu_sel <= sel_req.op;
                            alu_opa <= sel_req.a;
                            alu_opb <= sel_req.b;
                            alu_sub <= (sel_req.op == OP_SUB);
                            rsp_err <= 1'b0;
                        end
                    end
                end
                ST_EXEC: begin
                    // Last hold cycle: ALU outputs have settled, capture them.
                    if (cnt == CNT_W'(1)) begin
                        state     <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_data  <= pack_result(alu_sel, alu_y1, alu_y2, alu_y3);
                        rsp_flag  <= pack_flag(alu_sel, alu_cout, alu_m);
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        ptr       <= ~rsp_id;
                        rsp_valid <= 1'b0;
                        rsp_id    <= 1'b0;
                        rsp_data  <= '0;
                        rsp_flag  <= 1'b0;
                        rsp_err   <= 1'b0;
                        alu_sel   <= '0;
                        alu_opa   <= '0;
                        alu_opb   <= '0;
                        alu_sub   <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a combinational ALU stand-in, a transaction
// level reference model checked every cycle, and directed scenarios with
// hand-computed literal results.
module tb_alu_op_sequencer;

    localparam logic [2:0] T_ADD = 3'b000;
    localparam logic [2:0] T_SUB = 3'b001;
    localparam logic [2:0] T_MUL = 3'b010;
    localparam logic [2:0] T_SHF = 3'b011;
    localparam logic [2:0] T_DIV = 3'b100;
    localparam int T_LAT_FAST = 1;
    localparam int T_LAT_SLOW = 2;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [5:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [2:0]  alu_sel;
    logic [15:0] alu_opa;
    logic [15:0] alu_opb;
    logic        alu_cin;
    logic        alu_sub;
    logic [15:0] alu_y1;
    logic [31:0] alu_y2;
    logic [15:0] alu_y3;
    logic        alu_cout;
    logic        alu_m;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_data;
    logic        rsp_flag;
    logic        rsp_err;
    logic        busy;

    alu_op_sequencer #(.LAT_FAST(T_LAT_FAST), .LAT_SLOW(T_LAT_SLOW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .alu_sel(alu_sel), .alu_opa(alu_opa), .alu_opb(alu_opb),
        .alu_cin(alu_cin), .alu_sub(alu_sub),
        .alu_y1(alu_y1), .alu_y2(alu_y2), .alu_y3(alu_y3),
        .alu_cout(alu_cout), .alu_m(alu_m),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_flag(rsp_flag),
        .rsp_err(rsp_err), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU stand-in driven by the sequencer's select/operand buses.
    logic [16:0]        alu_s;
    logic signed [31:0] alu_p;
    always_comb begin
        alu_y1 = '0; alu_y2 = '0; alu_y3 = '0; alu_cout = 1'b0; alu_m = 1'b0;
        alu_s  = '0; alu_p  = '0;
        case (alu_sel)
            T_ADD: begin
                alu_s = {1'b0, alu_opa} + {1'b0, alu_opb};
                alu_y1 = alu_s[15:0]; alu_cout = alu_s[16];
            end
            T_SUB: begin
                alu_y1 = alu_opa - alu_opb;
                alu_m  = (alu_opa[15] != alu_opb[15]) && (alu_y1[15] != alu_opa[15]);
            end
            T_MUL: begin
                alu_p  = $signed({{16{alu_opa[15]}}, alu_opa}) * $signed({{16{alu_opb[15]}}, alu_opb});
                alu_y2 = alu_p;
            end
            T_SHF: begin
                alu_y3 = 16'(alu_opa << alu_opb);
                alu_y1 = 16'(alu_opa >> alu_opb);
            end
            T_DIV: begin
                if (alu_opb != 16'd0) begin
                    alu_y1 = alu_opa / alu_opb;
                    alu_y3 = alu_opa % alu_opb;
                end
            end
            default: ;
        endcase
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Expected response from the op rules, independent of any ALU bus.
    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [15:0] a,
                                               input logic [15:0] b, output logic flag,
                                               output logic err);
        logic [31:0]        r;
        logic [16:0]        s;
        logic [15:0]        d;
        logic signed [31:0] p;
        r = '0; flag = 1'b0; err = 1'b0;
        case (op)
            T_ADD: begin s = {1'b0, a} + {1'b0, b}; r = {16'h0, s[15:0]}; flag = s[16]; end
            T_SUB: begin d = a - b; r = {16'h0, d}; flag = (a[15] != b[15]) && (d[15] != a[15]); end
            T_MUL: begin p = $signed({{16{a[15]}}, a}) * $signed({{16{b[15]}}, b}); r = p; end
            T_SHF: r = {16'(a << b), 16'(a >> b)};
            T_DIV: begin
                if (b == 16'd0) err = 1'b1;
                else r = {16'(a % b), 16'(a / b)};
            end
            default: err = 1'b1;
        endcase
        return r;
    endfunction

    typedef struct packed {
        logic        id;
        logic [31:0] data;
        logic        flag;
        logic        err;
    } obs_t;

    obs_t       obs_arr [64];
    int         obs_wr = 0;
    int         obs_rd = 0;
    int         cyc = 0;
    int         div_sel_cycles = 0;
    logic [1:0] hs_seen = 2'b00;

    // Reference model state: one transaction with an absolute response cycle.
    logic        m_have = 1'b0;
    logic        m_ptr  = 1'b0;
    logic        m_id, m_err, m_flag;
    logic [2:0]  m_op;
    logic [15:0] m_a, m_b;
    logic [31:0] m_data;
    int          m_resp;

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        logic [1:0] exp_rdy;
        logic       exp_rv;
        logic       exp_alu;
        cyc++;
        hs_seen = req_valid & req_ready;
        if (alu_sel == T_DIV) div_sel_cycles++;
        if (rst) begin
            m_have = 1'b0;
            m_ptr  = 1'b0;
            chk("rst_ctrl", 32'({req_ready, alu_sel, alu_sub, alu_cin, busy, rsp_valid,
                                 rsp_id, rsp_flag, rsp_err}), 32'd0);
            chk("rst_opnd", {alu_opa, alu_opb}, 32'd0);
            chk("rst_data", rsp_data, 32'd0);
        end else begin
            exp_rdy = 2'b00;
            if (!m_have) begin
                if (req_valid[m_ptr])       exp_rdy[m_ptr]  = 1'b1;
                else if (req_valid[!m_ptr]) exp_rdy[!m_ptr] = 1'b1;
            end
            exp_rv  = m_have && (cyc >= m_resp);
            exp_alu = m_have && !m_err;
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            chk("busy", 32'(busy), 32'(m_have));
            chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
            chk("alu_sel", 32'(alu_sel), exp_alu ? 32'(m_op) : 32'd0);
            chk("alu_opa", 32'(alu_opa), exp_alu ? 32'(m_a) : 32'd0);
            chk("alu_opb", 32'(alu_opb), exp_alu ? 32'(m_b) : 32'd0);
            chk("alu_sub", 32'(alu_sub), 32'(exp_alu && (m_op == T_SUB)));
            chk("alu_cin", 32'(alu_cin), 32'd0);
            if (exp_rv) begin
                chk("rsp_id", 32'(rsp_id), 32'(m_id));
                chk("rsp_data", rsp_data, m_data);
                chk("rsp_flag", 32'(rsp_flag), 32'(m_flag));
                chk("rsp_err", 32'(rsp_err), 32'(m_err));
            end
            if (rsp_valid && rsp_ready) begin
                obs_arr[obs_wr % 64] = '{id: rsp_id, data: rsp_data, flag: rsp_flag, err: rsp_err};
                obs_wr++;
            end
            if (exp_rv && rsp_ready) begin
                m_have = 1'b0;
                m_ptr  = !m_id;
            end else if (exp_rdy != 2'b00) begin
                m_id   = exp_rdy[1];
                m_op   = m_id ? req_op[5:3]   : req_op[2:0];
                m_a    = m_id ? req_a[31:16]  : req_a[15:0];
                m_b    = m_id ? req_b[31:16]  : req_b[15:0];
                m_data = ref_result(m_op, m_a, m_b, m_flag, m_err);
                m_resp = cyc + (m_err ? 1 :
                         (((m_op == T_MUL) || (m_op == T_DIV)) ? T_LAT_SLOW : T_LAT_FAST) + 1);
                m_have = 1'b1;
            end
        end
    end

    // Advance one cycle; drop valid for requests accepted at this edge.
    task automatic tick();
        @(posedge clk);
        #1;
        req_valid = req_valid & ~hs_seen;
    endtask

    task automatic send(input int n, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        req_valid[n]        = 1'b1;
        req_op[n*3 +: 3]    = op;
        req_a[n*16 +: 16]   = a;
        req_b[n*16 +: 16]   = b;
    endtask

    task automatic quiet(input string name);
        logic done;
        done = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (req_valid == 2'b00 && !busy && !rsp_valid) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        chk({name, "_done"}, 32'(done), 32'd1);
    endtask

    task automatic check_obs(input string name, input logic id, input logic [31:0] data,
                             input logic flag, input logic err);
        obs_t o;
        chk({name, "_present"}, 32'(obs_wr > obs_rd), 32'd1);
        if (obs_wr > obs_rd) begin
            o = obs_arr[obs_rd % 64];
            obs_rd++;
            chk({name, "_id"}, 32'(o.id), 32'(id));
            chk({name, "_data"}, o.data, data);
            chk({name, "_flag"}, 32'(o.flag), 32'(flag));
            chk({name, "_err"}, 32'(o.err), 32'(err));
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int w;
        int d0;
        rst = 1'b1; req_valid = 2'b00; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // ADD 10+20, cycle-exact.
        send(0, T_ADD, 16'd10, 16'd20);
        @(negedge clk);
        chk("add_c0_ready", 32'(req_ready), 32'b01);
        tick();
        @(negedge clk);
        chk("add_c1_busy", 32'(busy), 32'd1);
        chk("add_c1_sel", 32'(alu_sel), 32'd0);
        chk("add_c1_opa", 32'(alu_opa), 32'd10);
        chk("add_c1_rv", 32'(rsp_valid), 32'd0);
        tick();
        @(negedge clk);
        chk("add_c2_rv", 32'(rsp_valid), 32'd1);
        chk("add_c2_data", rsp_data, 32'h0000001E);
        tick();
        quiet("add");
        check_obs("add", 1'b0, 32'h0000001E, 1'b0, 1'b0);

        // Simultaneous SUB (req0) and MUL (req1) after reset.
        pulse_reset();
        send(0, T_SUB, 16'd25, 16'd11);
        send(1, T_MUL, 16'hFFEF, 16'd24);
        quiet("submul");
        check_obs("sub", 1'b0, 32'h0000000E, 1'b0, 1'b0);
        check_obs("mul", 1'b1, 32'hFFFFFE68, 1'b0, 1'b0);

        // DIV 723/56, then divide by zero.
        send(1, T_DIV, 16'd723, 16'd56);
        quiet("div");
        check_obs("div", 1'b1, 32'h0033000C, 1'b0, 1'b0);
        d0 = div_sel_cycles;
        send(1, T_DIV, 16'd723, 16'd0);
        quiet("div0");
        check_obs("div0", 1'b1, 32'h00000000, 1'b0, 1'b1);
        chk("div0_alu_unused", 32'(div_sel_cycles - d0), 32'd0);

        // SHIFT with response back-pressure while req1 waits.
        rsp_ready = 1'b0;
        send(0, T_SHF, 16'hFF12, 16'd3);
        send(1, T_ADD, 16'd100, 16'd200);
        for (int i = 0; i < 20 && !rsp_valid; i++) tick();
        chk("shf_rv_seen", 32'(rsp_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("shf_hold_data", rsp_data, 32'hF8901FE2);
            chk("shf_hold_ready", 32'(req_ready), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        quiet("shf");
        check_obs("shf", 1'b0, 32'hF8901FE2, 1'b0, 1'b0);
        check_obs("shf_next", 1'b1, 32'h0000012C, 1'b0, 1'b0);

        // Reset in the middle of a MUL.
        send(0, T_MUL, 16'd3, 16'd4);
        tick();
        w = obs_wr;
        rst = 1'b1;
        #1;
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_ready", 32'(req_ready), 32'd0);
        chk("mrst_sel", 32'(alu_sel), 32'd0);
        chk("mrst_opnd", {alu_opa, alu_opb}, 32'd0);
        chk("mrst_rv", 32'(rsp_valid), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        send(0, T_ADD, 16'd5, 16'd6);
        send(1, T_ADD, 16'd7, 16'd8);
        @(negedge clk);
        chk("mrst_grant0", 32'(req_ready), 32'b01);
        quiet("mrst");
        chk("mrst_no_rsp", 32'(obs_arr[w % 64].data), 32'd11);
        check_obs("mrst_a", 1'b0, 32'd11, 1'b0, 1'b0);
        check_obs("mrst_b", 1'b1, 32'd15, 1'b0, 1'b0);

        // Illegal op from req1.
        send(1, 3'b111, 16'd1, 16'd1);
        @(negedge clk);
        chk("ill_ready", 32'(req_ready), 32'b10);
        tick();
        @(negedge clk);
        chk("ill_rv", 32'(rsp_valid), 32'd1);
        chk("ill_err", 32'(rsp_err), 32'd1);
        chk("ill_id", 32'(rsp_id), 32'd1);
        chk("ill_data", rsp_data, 32'd0);
        tick();
        quiet("ill");
        check_obs("ill", 1'b1, 32'd0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
